// File: rtl/regfile_dump.sv
// regfile_dump: walks a register file through its combinational read port
// and streams each register out as a valid/ready beat.
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle dump request (only honoured while idle)
//   ra / rd         read-port address out, read data back in the same cycle
//   out_valid/ready handshake for out_data/out_idx/out_last
//   busy            high whenever the walker is not idle
//   done            one-cycle pulse once the final beat has been accepted
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum beat
// (out_idx=0, out_last=1) after the LAST_REG beat.
module regfile_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IW = 5;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [IW-1:0]   r_ra, w_ra_nxt;
  logic [DW-1:0]   r_out_data, w_out_data_nxt;
  logic [IW-1:0]   r_out_idx, w_out_idx_nxt;
  logic            r_out_last, w_out_last_nxt;
  logic            r_out_valid, r_busy, r_done;
  logic            w_at_last;

  assign w_at_last = (r_idx == IW'(LAST_REG));

`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0]   r_csum, w_csum_nxt;
  logic            r_csum_beat, w_csum_beat_nxt;
`endif

  // Next-state and next-value logic
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_ra_nxt       = r_ra;
    w_out_data_nxt = r_out_data;
    w_out_idx_nxt  = r_out_idx;
    w_out_last_nxt = r_out_last;
`ifdef REGDUMP_CHECKSUM_EN
    w_csum_nxt      = r_csum;
    w_csum_beat_nxt = r_csum_beat;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_nxt   = IW'(FIRST_REG);
          w_ra_nxt    = IW'(FIRST_REG);
          w_state_nxt = S_READ;
`ifdef REGDUMP_CHECKSUM_EN
          w_csum_nxt      = '0;
          w_csum_beat_nxt = 1'b0;
`endif
        end
      end
      S_READ: begin
        w_out_data_nxt = rd;
        w_out_idx_nxt  = r_idx;
`ifdef REGDUMP_CHECKSUM_EN
        w_out_last_nxt = 1'b0;
`else
        w_out_last_nxt = w_at_last;
`endif
        w_state_nxt    = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          if (r_csum_beat) begin
            w_out_last_nxt = 1'b0;
            w_state_nxt    = S_DONE;
          end else begin
            w_csum_nxt = r_csum ^ r_out_data;
            if (w_at_last) begin
              // Stay in HOLD and re-present the beat as the checksum word.
              w_out_data_nxt  = r_csum ^ r_out_data;
              w_out_idx_nxt   = '0;
              w_out_last_nxt  = 1'b1;
              w_csum_beat_nxt = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + IW'(1);
              w_ra_nxt    = r_idx + IW'(1);
              w_state_nxt = S_READ;
            end
          end
`else
          if (w_at_last) begin
            w_out_last_nxt = 1'b0;
            w_state_nxt    = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_ra_nxt    = r_idx + IW'(1);
            w_state_nxt = S_READ;
          end
`endif
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; status flags are registered from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ra        <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_ra        <= w_ra_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_valid <= (w_state_nxt == S_HOLD);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  // Checksum accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum      <= '0;
      r_csum_beat <= 1'b0;
    end else begin
      r_csum      <= w_csum_nxt;
      r_csum_beat <= w_csum_beat_nxt;
    end
  end
`endif

  assign ra        = r_ra;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
